// File: rtl/fc_pkg.sv
// Fibre Channel shared types: port states and the primitive ordered-set words.
package fc;

    typedef enum logic [3:0] {OL1, OL2, LR1, LR2, LR3, AC, LF1, LF2} port_state_t;

    localparam logic [3:0]  K_LEAD = 4'b1000;
    localparam logic [31:0] NOS    = 32'hBC55BF45;
    localparam logic [31:0] IDLE   = 32'hBC95B5B5;
    localparam logic [31:0] OLS    = 32'hBC358A55;
    localparam logic [31:0] LR     = 32'hBC49BF49;
    localparam logic [31:0] LRR    = 32'hBC35DF49;

    // Primitive transmitted continuously while the port sits in a state.
    function automatic logic [31:0] state_prim(port_state_t st);
        case (st)
            OL1, LF1: state_prim = OLS;
            OL2, LR1: state_prim = LR;
            LR2:      state_prim = LRR;
            LF2:      state_prim = NOS;
            default:  state_prim = IDLE;
        endcase
    endfunction

endpackage

// File: rtl/fc_prim_seq_detect.sv
// Recognises primitive sequences (3 identical K-lead words) and loss of sync on the RX stream.
module fc_prim_seq_detect
    import fc::*;
#(
    parameter int unsigned LOS_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [35:0] rx_data,
    input  logic        rx_valid,
    output logic        seq_nos,
    output logic        seq_ols,
    output logic        seq_lr,
    output logic        seq_lrr,
    output logic        seq_idle,
    output logic        los
);

    localparam int unsigned   LW      = $clog2(LOS_CYCLES + 1);
    localparam logic [LW-1:0] LOS_MAX = LW'(LOS_CYCLES);

    logic [31:0]   last_q;
    logic [1:0]    run_q, run_d;
    logic [LW-1:0] los_cnt_q, los_cnt_d;
    logic          kword, same, third;

    always_comb begin
        kword = rx_valid && (rx_data[35:32] == K_LEAD);
        same  = kword && (run_q != 2'd0) && (rx_data[31:0] == last_q);
        third = same && (run_q == 2'd2);

        // Run length saturates at 3 so a long sequence pulses only once.
        run_d = run_q;
        if (rx_valid) begin
            if (!kword)               run_d = 2'd0;
            else if (!same)           run_d = 2'd1;
            else if (run_q != 2'd3)   run_d = run_q + 2'd1;
        end

        seq_nos  = third && (rx_data[31:0] == NOS);
        seq_ols  = third && (rx_data[31:0] == OLS);
        seq_lr   = third && (rx_data[31:0] == LR);
        seq_lrr  = third && (rx_data[31:0] == LRR);
        seq_idle = third && (rx_data[31:0] == IDLE);

        los_cnt_d = rx_valid ? '0 : ((los_cnt_q == LOS_MAX) ? los_cnt_q : los_cnt_q + 1'b1);
        los       = !rx_valid && (los_cnt_q >= LOS_MAX - 1'b1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q    <= '0;
            run_q     <= 2'd0;
            los_cnt_q <= '0;
        end else begin
            if (kword) last_q <= rx_data[31:0];
            run_q     <= run_d;
            los_cnt_q <= los_cnt_d;
        end
    end

endmodule

// File: rtl/fc_link_ctrl.sv
// Fibre Channel port-state controller: link init sequencing, TX mux and frame abort/flush.
module fc_link_ctrl
    import fc::*;
#(
    parameter int unsigned TOV_CYCLES = 21_250_000,
    parameter int unsigned LOS_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [35:0] rx_data,
    input  logic        rx_valid,
    output logic [35:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [35:0] frm_data,
    input  logic        frm_valid,
    input  logic        frm_sop,
    input  logic        frm_eop,
    output logic        frm_ready,
    input  logic        link_reset_req,
    input  logic        offline_req,
    output port_state_t port_state,
    output logic        link_up,
    output logic [15:0] frames_aborted
);

    localparam int unsigned   TW      = $clog2(TOV_CYCLES + 1);
    localparam logic [TW-1:0] TOV_MAX = TW'(TOV_CYCLES);

    port_state_t   state_q, state_d;
    logic [TW-1:0] timer_q, timer_d, timer_inc;
    logic [35:0]   tx_data_q, tx_data_d;
    logic          tx_valid_q, link_up_q;
    logic          flush_q, flush_d, open_q, open_d;
    logic [15:0]   aborted_q, aborted_d;
    logic          seq_nos, seq_ols, seq_lr, seq_lrr, seq_idle, los;
    logic          load, pass;

    fc_prim_seq_detect #(
        .LOS_CYCLES(LOS_CYCLES)
    ) u_detect (
        .clk      (clk),
        .reset_n  (reset_n),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .seq_nos  (seq_nos),
        .seq_ols  (seq_ols),
        .seq_lr   (seq_lr),
        .seq_lrr  (seq_lrr),
        .seq_idle (seq_idle),
        .los      (los)
    );

    always_comb begin : next_state
        timer_inc = (timer_q == TOV_MAX) ? timer_q : timer_q + 1'b1;
        state_d   = state_q;
        if (offline_req)                                         state_d = OL1;
        else if (los && state_q != LF2)                          state_d = LF2;
        else if (seq_nos && state_q != LF1)                      state_d = LF1;
        else if (seq_ols && state_q != OL2)                      state_d = OL2;
        else if (seq_lr && state_q != LR2)                       state_d = LR2;
        else if (seq_lrr && state_q inside {LR1, LR2, OL2})      state_d = LR3;
        else if (seq_idle && state_q inside {LR2, LR3})          state_d = AC;
        else if (link_reset_req && state_q == AC)                state_d = LR1;
        // Timeout counts the cycle being evaluated, so the port dwells exactly TOV_CYCLES.
        else if (timer_inc == TOV_MAX && state_q inside {OL2, LR1, LR2, LR3}) state_d = LF1;
        timer_d = (state_d != state_q) ? '0 : timer_inc;
    end

    always_comb begin : tx_path
        frm_ready = flush_q || (state_q == AC && tx_ready);
        pass      = (state_q == AC) && !flush_q && frm_valid && tx_ready;
        load      = tx_ready || !tx_valid_q;

        tx_data_d = tx_data_q;
        if (load) begin
            if (state_q != AC) tx_data_d = {K_LEAD, state_prim(state_q)};
            else if (pass)     tx_data_d = frm_data;
            else               tx_data_d = {K_LEAD, IDLE};
        end

        open_d    = open_q;
        flush_d   = flush_q;
        aborted_d = aborted_q;
        if (flush_q && frm_valid && frm_eop) flush_d = 1'b0;
        if (pass && frm_eop)      open_d = 1'b0;
        else if (pass && frm_sop) open_d = 1'b1;
        // A word accepted in the exit cycle still counts; abort only if the frame stays open.
        if (state_q == AC && state_d != AC && open_d) begin
            open_d  = 1'b0;
            flush_d = 1'b1;
            if (aborted_q != 16'hFFFF) aborted_d = aborted_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= OL1;
            timer_q    <= '0;
            tx_data_q  <= {K_LEAD, NOS};
            tx_valid_q <= 1'b0;
            link_up_q  <= 1'b0;
            flush_q    <= 1'b0;
            open_q     <= 1'b0;
            aborted_q  <= '0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= 1'b1;
            link_up_q  <= (state_d == AC);
            flush_q    <= flush_d;
            open_q     <= open_d;
            aborted_q  <= aborted_d;
        end
    end

    assign tx_data        = tx_data_q;
    assign tx_valid       = tx_valid_q;
    assign port_state     = state_q;
    assign link_up        = link_up_q;
    assign frames_aborted = aborted_q;

endmodule
